as_seq_list: RTL



---
 rtl/as_seq_list_pkg.sv | 38 +++
 rtl/as_seq_list_if.sv | 26 ++
 rtl/as_seq_list_as_ch_ctx.sv | 40 ++++
 rtl/as_seq_list.sv | 90 +++++++++
 4 files changed

// File: rtl/as_seq_list_pkg.sv
// Shared constants, allocation-set field layout and helpers for the as_seq_list program store.
package as_seq_list_pkg;

  localparam int unsigned VEC_ID_W       = 4;
  localparam int unsigned STAGE_W        = 3;
  localparam int unsigned DATA_ADDR_W    = 12;
  localparam int unsigned ALLOC_LEN_W    = 10;
  localparam int unsigned REGFILE_ADDR_W = 5;
  localparam int unsigned PS_ADDR_W      = 7;
  localparam int unsigned PS_DEPTH       = 2 ** PS_ADDR_W;
  localparam int unsigned N_CH           = 4;
  localparam int unsigned CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Field LSB offsets, LSB-first; each builds on the one below it
  localparam int unsigned DADDR1_OFF = 0;
  localparam int unsigned DADDR0_OFF = DADDR1_OFF + DATA_ADDR_W;
  localparam int unsigned ALEN_OFF   = DADDR0_OFF + DATA_ADDR_W;
  localparam int unsigned RF1_OFF    = ALEN_OFF + ALLOC_LEN_W;
  localparam int unsigned RF0_OFF    = RF1_OFF + REGFILE_ADDR_W;
  localparam int unsigned VEC_OFF    = RF0_OFF + REGFILE_ADDR_W;
  localparam int unsigned STAGE_OFF  = VEC_OFF + VEC_ID_W;
  localparam int unsigned AS_W       = STAGE_OFF + STAGE_W;

  typedef struct packed {
    logic [STAGE_W-1:0]        stage;
    logic [VEC_ID_W-1:0]       vec_id;
    logic [REGFILE_ADDR_W-1:0] rf_addr0;
    logic [REGFILE_ADDR_W-1:0] rf_addr1;
    logic [ALLOC_LEN_W-1:0]    alloc_len;
    logic [DATA_ADDR_W-1:0]    data_addr0;
    logic [DATA_ADDR_W-1:0]    data_addr1;
  } as_t;

  function automatic as_t as_gnd();
    return as_t'('0);
  endfunction

endpackage

// File: rtl/as_seq_list_if.sv
// Fetch handshake and returned allocation-set bus; as_perr exists only with ASLIST_PARITY_EN.
interface as_seq_list_if;
  import as_seq_list_pkg::*;

  logic                 fetch_vld;
  logic [CH_W-1:0]      fetch_ch;
  logic                 fetch_rdy;
  logic                 as_vld;
  as_t                  as_word;
  logic [CH_W-1:0]      as_ch;
  logic [PS_ADDR_W-1:0] as_addr;
  logic                 as_wrap;
`ifdef ASLIST_PARITY_EN
  logic                 as_perr;

  modport master (output fetch_vld, fetch_ch,
                  input  fetch_rdy, as_vld, as_word, as_ch, as_addr, as_wrap, as_perr);
  modport slave  (input  fetch_vld, fetch_ch,
                  output fetch_rdy, as_vld, as_word, as_ch, as_addr, as_wrap, as_perr);
`else
  modport master (output fetch_vld, fetch_ch,
                  input  fetch_rdy, as_vld, as_word, as_ch, as_addr, as_wrap);
  modport slave  (input  fetch_vld, fetch_ch,
                  output fetch_rdy, as_vld, as_word, as_ch, as_addr, as_wrap);
`endif
endinterface

// File: rtl/as_seq_list_as_ch_ctx.sv
// One channel's region (base/last) and program counter with wrap-to-base stepping.
module as_ch_ctx
  import as_seq_list_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [PS_ADDR_W-1:0] cfg_base,
  input  logic [PS_ADDR_W-1:0] cfg_last,
  input  logic                 restart,
  input  logic                 fetch,
  output logic [PS_ADDR_W-1:0] rd_addr_c,
  output logic                 wrap_c
);

  logic [PS_ADDR_W-1:0] base_q;
  logic [PS_ADDR_W-1:0] last_q;
  logic [PS_ADDR_W-1:0] pc_q;

  // A restart in the fetch cycle redirects that very read to base
  assign rd_addr_c = restart ? base_q : pc_q;
  assign wrap_c    = (rd_addr_c == last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      last_q <= '0;
      pc_q   <= '0;
    end else if (cfg_we) begin
      base_q <= cfg_base;
      pc_q   <= cfg_base;
      last_q <= (cfg_last < cfg_base) ? cfg_base : cfg_last;
    end else if (fetch) begin
      pc_q <= wrap_c ? base_q : rd_addr_c + PS_ADDR_W'(1);
    end else if (restart) begin
      pc_q <= base_q;
    end
  end

endmodule

// File: rtl/as_seq_list.sv
// Multi-channel allocation-set program store; optional parity via ASLIST_PARITY_EN.
module as_seq_list
  import as_seq_list_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 prog_we,
  input  logic [PS_ADDR_W-1:0] prog_addr,
  input  logic [AS_W-1:0]      prog_as,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [PS_ADDR_W-1:0] cfg_base,
  input  logic [PS_ADDR_W-1:0] cfg_last,
  input  logic [N_CH-1:0]      restart,
`ifdef ASLIST_PARITY_EN
  input  logic                 perr_inj,
`endif
  as_seq_list_if.slave         bus
);

`ifdef ASLIST_PARITY_EN
  localparam int unsigned MEM_W = AS_W + 1;
`else
  localparam int unsigned MEM_W = AS_W;
`endif

  logic [MEM_W-1:0]     mem [PS_DEPTH];
  logic [PS_ADDR_W-1:0] ch_addr [N_CH];
  logic [N_CH-1:0]      ch_wrap;
  logic                 accept_c;
  logic [PS_ADDR_W-1:0] rd_addr_c;
  logic [MEM_W-1:0]     rd_word_c;

  assign bus.fetch_rdy = en & ~prog_we & ~cfg_we;
  assign accept_c      = bus.fetch_vld & bus.fetch_rdy;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    as_ch_ctx u_ctx (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we && (cfg_ch == CH_W'(g))),
      .cfg_base  (cfg_base),
      .cfg_last  (cfg_last),
      .restart   (restart[g]),
      .fetch     (accept_c && (bus.fetch_ch == CH_W'(g))),
      .rd_addr_c (ch_addr[g]),
      .wrap_c    (ch_wrap[g])
    );
  end

  assign rd_addr_c = ch_addr[bus.fetch_ch];
  assign rd_word_c = mem[rd_addr_c];

  // Program store: no reset; parity bit (when present) sits above the word
  always_ff @(posedge clk) begin
    if (prog_we) begin
`ifdef ASLIST_PARITY_EN
      mem[prog_addr] <= {(^prog_as) ^ perr_inj, prog_as};
`else
      mem[prog_addr] <= prog_as;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.as_vld  <= 1'b0;
      bus.as_word <= as_gnd();
      bus.as_ch   <= '0;
      bus.as_addr <= '0;
      bus.as_wrap <= 1'b0;
`ifdef ASLIST_PARITY_EN
      bus.as_perr <= 1'b0;
`endif
    end else begin
      bus.as_vld <= accept_c;
      if (accept_c) begin
        bus.as_word <= as_t'(rd_word_c[AS_W-1:0]);
        bus.as_ch   <= bus.fetch_ch;
        bus.as_addr <= rd_addr_c;
        bus.as_wrap <= ch_wrap[bus.fetch_ch];
`ifdef ASLIST_PARITY_EN
        bus.as_perr <= (^rd_word_c[AS_W-1:0]) != rd_word_c[AS_W];
`endif
      end
    end
  end

endmodule
